// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial -- digit-serial BCD adder/subtractor, one decimal digit per clock,
// least-significant digit first. Subtraction uses 10's complement: each B digit is
// 9's-complemented and the incoming borrow is inverted into the carry chain.
//
// Ports
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   start      : request, accepted only while busy=0 (IDLE or DONE)
//   sub, cin   : 0: A+B+cin   1: A-B-cin (cin acts as borrow-in)
//   a, b       : packed BCD operands, digit 0 in [3:0]; latched on the accept edge
//   busy       : operation in progress
//   done       : one-cycle pulse; s/cout/err are valid from this cycle on
//   s          : BCD result, held until the next accepted start
//   cout       : add: decimal carry-out, sub: borrow-out
//   err        : some nibble of the latched a or b was above 9

// One decimal digit slice: returns the BCD sum digit and the decimal carry.
module bcd_digit (
    input  logic [3:0] ad,
    input  logic [3:0] bd,
    input  logic       sub,
    input  logic       ci,
    output logic [3:0] sd,
    output logic       co
);
    logic [3:0] bx;
    logic [4:0] t;

    always_comb begin
        // 9's complement wraps modulo 16 when bd is not a valid digit
        bx = sub ? (4'd9 - bd) : bd;
        t  = {1'b0, ad} + {1'b0, bx} + {4'b0, ci};
        co = (t > 5'd9);
        sd = co ? (t[3:0] + 4'd6) : t[3:0];
    end
endmodule

module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] s,
    output logic                cout,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q;
    logic            sub_q;
    logic            c_q;
    logic [IW-1:0]   idx;
    logic            accept, last, bad_in;
    logic [3:0]      ad, bd, sd;
    logic            cn;

    assign accept = start && (state_q != RUN);
    assign last   = (idx == IW'(DIGITS - 1));
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

    // Digit currently being processed
    assign ad = a_q[{idx, 2'b00} +: 4];
    assign bd = b_q[{idx, 2'b00} +: 4];

    bcd_digit u_digit (
        .ad  (ad),
        .bd  (bd),
        .sub (sub_q),
        .ci  (c_q),
        .sd  (sd),
        .co  (cn)
    );

    // Invalid-digit scan of the raw operands, captured on accept
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                bad_in = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            c_q   <= 1'b0;
            idx   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            // For subtract, a borrow-in of 0 means +1 in the 10's complement chain
            c_q   <= sub ? ~cin : cin;
            idx   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            err   <= bad_in;
        end else if (state_q == RUN) begin
            s[{idx, 2'b00} +: 4] <= sd;
            c_q <= cn;
            idx <= idx + 1'b1;
            // In 10's complement, no final carry means the result went negative
            if (last) cout <= sub_q ? ~cn : cn;
        end
    end
endmodule
